// File: rtl/gates_pkg.sv
// Shared definitions for the two-input gates block and its self-test sequencer:
// FSM states, response bit positions and the golden truth table.
package gates_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      CHECK,
      DONE
   } state_t;

   localparam int Y_AND  = 0;
   localparam int Y_OR   = 1;
   localparam int Y_NAND = 2;
   localparam int Y_NOR  = 3;
   localparam int Y_XOR  = 4;
   localparam int Y_XNOR = 5;

   function automatic logic [5:0] gates_expected(input logic a, input logic b);
      logic [5:0] e;
      e         = '0;
      e[Y_AND]  = a & b;
      e[Y_OR]   = a | b;
      e[Y_NAND] = ~(a & b);
      e[Y_NOR]  = ~(a | b);
      e[Y_XOR]  = a ^ b;
      e[Y_XNOR] = ~(a ^ b);
      return e;
   endfunction

endpackage

// File: rtl/gates_bist.sv
// Self-test sequencer for the gates block: sweeps {a,b} through all four vectors,
// lets each settle, checks y against the golden table and reports pass/fail.
module gates_bist
   import gates_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int PASSES        = 1,
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             a,
   output logic             b,
   input  logic [5:0]       y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [1:0]       first_fail_vec,
   output logic [5:0]       first_fail_mask
);

   localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);
   localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

   state_t            state_q, state_d;
   logic              start_seen;
   logic [1:0]        vec;
   logic [CNT_W-1:0]  cnt;
   logic [PASS_W-1:0] pass_idx;
   logic [5:0]        mismatch_mask;
   logic              mismatch;
   logic              last_vec;

   assign mismatch_mask = y ^ gates_expected(vec[1], vec[0]);
   assign mismatch      = |mismatch_mask;
   assign last_vec      = (vec == 2'd3) && (pass_idx == PASS_LAST);

   assign a    = vec[1];
   assign b    = vec[0];
   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

   // NOTE: default assignment first keeps this combinational block latch-free.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_seen) state_d = SETTLE;
         SETTLE:  if (cnt == CNT_LAST) state_d = CHECK;
         CHECK:   state_d = last_vec ? DONE : SETTLE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses <= so every register updates from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_seen      <= 1'b0;
         vec             <= '0;
         cnt             <= '0;
         pass_idx        <= '0;
         pass            <= 1'b0;
         err_cnt         <= '0;
         first_fail_vec  <= '0;
         first_fail_mask <= '0;
      end else begin
         // Gated so a start seen while busy (DONE included) is never remembered.
         start_seen <= start && (state_q == IDLE);
         case (state_q)
            IDLE: begin
               if (start_seen) begin
                  vec             <= '0;
                  cnt             <= '0;
                  pass_idx        <= '0;
                  pass            <= 1'b0;
                  err_cnt         <= '0;
                  first_fail_vec  <= '0;
                  first_fail_mask <= '0;
               end
            end
            SETTLE: begin
               if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
            end
            CHECK: begin
               if (mismatch) begin
                  if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
                  if (err_cnt == '0) begin
                     first_fail_vec  <= vec;
                     first_fail_mask <= mismatch_mask;
                  end
               end
               if (last_vec) begin
                  pass <= (err_cnt == '0) && !mismatch;
               end else begin
                  vec <= vec + 2'd1;
                  cnt <= '0;
                  if (vec == 2'd3) pass_idx <= pass_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gates_bist.sv
// Directed bench for gates_bist: a behavioural gates model with fault injection
// drives one default instance; a second instance sees y stuck at all ones.
module tb_gates_bist;

   logic       clk = 1'b0;
   logic       rst;
   logic       start0, start1;
   logic       a0, b0, busy0, done0, pass0;
   logic [7:0] err0;
   logic [1:0] ffv0;
   logic [5:0] ffm0, y0;
   logic       a1, b1, busy1, done1, pass1;
   logic [1:0] err1;
   logic [1:0] ffv1;
   logic [5:0] ffm1;
   logic       fault_y5, glitch, glitch_en;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // Gates model written out independently of the package table.
   always_comb begin
      y0 = {~(a0 ^ b0), a0 ^ b0, ~(a0 | b0), ~(a0 & b0), a0 | b0, a0 & b0};
      if (fault_y5) y0[4] = 1'b0;
      if (glitch)   y0 = ~y0;
   end

   gates_bist dut0 (
      .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .y(y0),
      .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
      .first_fail_vec(ffv0), .first_fail_mask(ffm0)
   );

   gates_bist #(.SETTLE_CYCLES(2), .PASSES(2), .ERR_W(2)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .y(6'b111111),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
      .first_fail_vec(ffv1), .first_fail_mask(ffm1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Start sampled at the posedge called edge 0; returns just after edge 0.
   task automatic pulse_start0();
      @(negedge clk);
      start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      check("busy_edge0", busy0, 1'b0);
   endtask

   // Counts edges from 1 after edge 0 until done is seen; -1 on timeout.
   task automatic run_wait(input bit sel, output int done_edge,
                           output logic [23:0] ab_seq, output logic busy_first);
      done_edge  = -1;
      ab_seq     = '0;
      busy_first = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (k <= 12) ab_seq = {ab_seq[21:0], a0, b0};
         if (k == 1)  busy_first = sel ? busy1 : busy0;
         glitch = glitch_en && (k % 3 != 0);
         if (sel ? done1 : done0) begin
            done_edge = k;
            break;
         end
      end
      glitch = 1'b0;
   endtask

   int          de;
   logic [23:0] seq;
   logic        bf;
   logic        done_seen;

   initial begin
      start0 = 0; start1 = 0; fault_y5 = 0; glitch = 0; glitch_en = 0; rst = 0;
      #3 rst = 1;
      #2;
      check("rst_a", a0, 0);
      check("rst_b", b0, 0);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_pass", pass0, 0);
      check("rst_err", err0, 0);
      check("rst_ffv", ffv0, 0);
      check("rst_ffm", ffm0, 0);
      check("rst_busy1", busy1, 0);
      repeat (2) @(negedge clk);
      rst = 0;

      // Fault-free run with defaults.
      pulse_start0();
      run_wait(0, de, seq, bf);
      check("good_done_edge", de, 13);
      check("good_busy_edge1", bf, 1);
      check("good_ab_seq", seq, 24'h015ABF);
      check("good_pass", pass0, 1);
      check("good_err", err0, 0);
      check("good_ffv", ffv0, 0);
      check("good_ffm", ffm0, 0);
      // Start raised during the DONE cycle must be ignored.
      @(negedge clk);
      start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      check("done_one_cycle", done0, 0);
      check("busy_after_done", busy0, 0);
      check("pass_held", pass0, 1);
      repeat (2) begin @(posedge clk); #1; end
      check("start_in_done_ignored", busy0, 0);

      // Glitching y during SETTLE plus a stray start mid-run.
      glitch_en = 1'b1;
      pulse_start0();
      fork
         run_wait(0, de, seq, bf);
         begin
            repeat (5) @(negedge clk);
            start0 = 1'b1;
            repeat (2) @(negedge clk);
            start0 = 1'b0;
         end
      join
      glitch_en = 1'b0;
      check("glitch_done_edge", de, 13);
      check("glitch_pass", pass0, 1);
      check("glitch_err", err0, 0);
      @(posedge clk); #1;

      // y5 stuck at 0.
      fault_y5 = 1'b1;
      pulse_start0();
      run_wait(0, de, seq, bf);
      check("y5_done_edge", de, 13);
      check("y5_err", err0, 2);
      check("y5_ffv", ffv0, 2'b01);
      check("y5_ffm", ffm0, 6'b010000);
      check("y5_pass", pass0, 0);
      @(posedge clk); #1;

      // Start held high: second run follows the IDLE cycle after DONE.
      @(negedge clk);
      start0 = 1'b1;
      @(posedge clk); #1;
      run_wait(0, de, seq, bf);
      check("held1_done_edge", de, 13);
      @(posedge clk); #1;
      check("held_idle_busy", busy0, 0);
      check("held_idle_err", err0, 2);
      @(posedge clk); #1;
      check("held_accept_busy", busy0, 0);
      fork
         run_wait(0, de, seq, bf);
         begin @(negedge clk); start0 = 1'b0; end
      join
      check("held2_busy_edge1", bf, 1);
      check("held2_done_edge", de, 13);
      check("held2_err_cleared", err0, 2);
      check("held2_ffv", ffv0, 2'b01);
      @(posedge clk); #1;

      // y stuck at all ones, ERR_W=2, PASSES=2.
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      run_wait(1, de, seq, bf);
      check("ones_done_edge", de, 25);
      check("ones_busy_edge1", bf, 1);
      check("ones_err_sat", err1, 3);
      check("ones_ffv", ffv1, 2'b00);
      check("ones_ffm", ffm1, 6'b010011);
      check("ones_pass", pass1, 0);
      @(posedge clk); #1;

      // Reset during SETTLE of vector 10.
      pulse_start0();
      repeat (8) @(posedge clk);
      #1;
      check("pre_rst_a", a0, 1);
      check("pre_rst_b", b0, 0);
      check("pre_rst_err", err0, 1);
      #1 rst = 1'b1;
      #1;
      check("midrst_a", a0, 0);
      check("midrst_busy", busy0, 0);
      check("midrst_err", err0, 0);
      check("midrst_ffv", ffv0, 0);
      check("midrst_ffm", ffm0, 0);
      done_seen = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done0) done_seen = 1'b1;
      end
      check("midrst_no_done", done_seen, 0);
      @(negedge clk);
      rst = 1'b0;
      fault_y5 = 1'b0;
      pulse_start0();
      run_wait(0, de, seq, bf);
      check("post_rst_done_edge", de, 13);
      check("post_rst_pass", pass0, 1);
      check("post_rst_err", err0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
